reg_file_2w2r: RTL and testbench

Parametrised successor to the single-write register file in the MIPS datapath.
- Two combinational read ports and two synchronous write ports (ALU writeback plus load writeback).
- Synchronous clear of all registers on reset, with register 0 hard-wired to zero.
- Per-register pending-write scoreboard, so the decode stage can detect RAW hazards against in-flight producers.

---
 rtl/reg_file_2w2r_pkg.sv | 18 +
 rtl/reg_file_2w2r_scoreboard.sv | 53 +++++
 rtl/reg_file_2w2r.sv | 104 ++++++++++
 tb/tb_reg_file_2w2r.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_2w2r_pkg.sv
// Shared constants and types for the dual-write register file and the pipeline writeback stage.
// Build option: define REG_BYPASS_EN in the top for same-cycle write-through forwarding.
package reg_file_2w2r_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

    // Writeback request at the default geometry; the writeback stage drives one per port.
    typedef struct packed {
        logic                  en;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wr_req_t;

    localparam wr_req_t WR_REQ_IDLE = '{en: 1'b0, addr: '0, data: '0};

endpackage

// File: rtl/reg_file_2w2r_scoreboard.sv
// Per-register pending-write scoreboard: issue sets a bit, writeback on either port clears it,
// and a same-edge set beats a clear because the set belongs to a newer producer.
module reg_scoreboard
    import reg_file_2w2r_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_set,
    input  logic [ADDR_W-1:0] i_set_addr,
    input  logic              i_clr1,
    input  logic [ADDR_W-1:0] i_clr1_addr,
    input  logic              i_clr2,
    input  logic [ADDR_W-1:0] i_clr2_addr,
    input  logic [ADDR_W-1:0] i_rd_addr1,
    input  logic [ADDR_W-1:0] i_rd_addr2,
    output logic              o_busy1,
    output logic              o_busy2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;

    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr1) begin
            w_busy_nxt[i_clr1_addr] = 1'b0;
        end
        if (i_clr2) begin
            w_busy_nxt[i_clr2_addr] = 1'b0;
        end
        if (i_set) begin
            w_busy_nxt[i_set_addr] = 1'b1;
        end
        // Register 0 never has a pending producer.
        w_busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_busy1 = r_busy[i_rd_addr1];
    assign o_busy2 = r_busy[i_rd_addr2];

endmodule

// File: rtl/reg_file_2w2r.sv
// Two-read / two-write register file with r0 hard-wired to zero and a RAW-hazard scoreboard.
// Build option: REG_BYPASS_EN forwards same-cycle write data (port 2 first) to the read ports.
module reg_file_2w2r
    import reg_file_2w2r_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              REG_clk,
    input  logic              REG_rst,
    input  logic [ADDR_W-1:0] REG_address1,
    input  logic [ADDR_W-1:0] REG_address2,
    output logic [DATA_W-1:0] REG_data_out1,
    output logic [DATA_W-1:0] REG_data_out2,
    input  logic              REG_write_1,
    input  logic [ADDR_W-1:0] REG_address_wr,
    input  logic [DATA_W-1:0] REG_data_wr_in1,
    input  logic              REG_write_2,
    input  logic [ADDR_W-1:0] REG_address_wr2,
    input  logic [DATA_W-1:0] REG_data_wr_in2,
    input  logic              REG_busy_set,
    input  logic [ADDR_W-1:0] REG_busy_addr,
    output logic              REG_busy1,
    output logic              REG_busy2
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_wr1_ok;
    logic w_wr2_ok;
    logic w_sb_busy1;
    logic w_sb_busy2;

    assign w_wr1_ok = REG_write_1 && (REG_address_wr  != ZERO_ADDR);
    assign w_wr2_ok = REG_write_2 && (REG_address_wr2 != ZERO_ADDR);

    // Port 2 is assigned last so it wins a same-address conflict.
    always_ff @(posedge REG_clk) begin
        if (REG_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr1_ok) begin
                r_mem[REG_address_wr] <= REG_data_wr_in1;
            end
            if (w_wr2_ok) begin
                r_mem[REG_address_wr2] <= REG_data_wr_in2;
            end
        end
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .i_clk       (REG_clk),
        .i_rst       (REG_rst),
        .i_set       (REG_busy_set),
        .i_set_addr  (REG_busy_addr),
        .i_clr1      (w_wr1_ok),
        .i_clr1_addr (REG_address_wr),
        .i_clr2      (w_wr2_ok),
        .i_clr2_addr (REG_address_wr2),
        .i_rd_addr1  (REG_address1),
        .i_rd_addr2  (REG_address2),
        .o_busy1     (w_sb_busy1),
        .o_busy2     (w_sb_busy2)
    );

    always_comb begin
        REG_data_out1 = (REG_address1 == ZERO_ADDR) ? '0 : r_mem[REG_address1];
        REG_data_out2 = (REG_address2 == ZERO_ADDR) ? '0 : r_mem[REG_address2];
        REG_busy1     = w_sb_busy1;
        REG_busy2     = w_sb_busy2;
`ifdef REG_BYPASS_EN
        if (REG_rst) begin
            // The reset edge discards the pending writes, so nothing is forwarded.
            REG_data_out1 = '0;
            REG_data_out2 = '0;
            REG_busy1     = 1'b0;
            REG_busy2     = 1'b0;
        end else begin
            if (w_wr2_ok && (REG_address_wr2 == REG_address1)) begin
                REG_data_out1 = REG_data_wr_in2;
                REG_busy1     = 1'b0;
            end else if (w_wr1_ok && (REG_address_wr == REG_address1)) begin
                REG_data_out1 = REG_data_wr_in1;
                REG_busy1     = 1'b0;
            end
            if (w_wr2_ok && (REG_address_wr2 == REG_address2)) begin
                REG_data_out2 = REG_data_wr_in2;
                REG_busy2     = 1'b0;
            end else if (w_wr1_ok && (REG_address_wr == REG_address2)) begin
                REG_data_out2 = REG_data_wr_in1;
                REG_busy2     = 1'b0;
            end
        end
`endif
    end

endmodule

// File: tb/tb_reg_file_2w2r.sv
// Directed self-checking bench for reg_file_2w2r (expectations follow REG_BYPASS_EN when defined).
module tb_reg_file_2w2r;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] addr1, addr2;
    logic [DATA_W-1:0] out1, out2;
    logic              we1, we2;
    logic [ADDR_W-1:0] waddr1, waddr2;
    logic [DATA_W-1:0] wdata1, wdata2;
    logic              bset;
    logic [ADDR_W-1:0] baddr;
    logic              busy1, busy2;

    int checks = 0;
    int errors = 0;

    reg_file_2w2r #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .REG_clk         (clk),
        .REG_rst         (rst),
        .REG_address1    (addr1),
        .REG_address2    (addr2),
        .REG_data_out1   (out1),
        .REG_data_out2   (out2),
        .REG_write_1     (we1),
        .REG_address_wr  (waddr1),
        .REG_data_wr_in1 (wdata1),
        .REG_write_2     (we2),
        .REG_address_wr2 (waddr2),
        .REG_data_wr_in2 (wdata2),
        .REG_busy_set    (bset),
        .REG_busy_addr   (baddr),
        .REG_busy1       (busy1),
        .REG_busy2       (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        we1 = 0; we2 = 0; bset = 0;
        waddr1 = '0; waddr2 = '0; wdata1 = '0; wdata2 = '0; baddr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs(); addr1 = '0; addr2 = '0;
        tick(); tick();
        rst = 0;
        for (int i = 0; i < 32; i++) begin
            addr1 = ADDR_W'(i);
            addr2 = ADDR_W'(31 - i);
            #1;
            checks++;
            if (out1 !== 32'h0 || out2 !== 32'h0) begin
                errors++;
                $display("FAIL reset_data a=%0d: out1=%h out2=%h expected 0", i, out1, out2);
            end
            checks++;
            if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy a=%0d: busy1=%b busy2=%b expected 0", i, busy1, busy2);
            end
        end
    endtask

    task automatic test_write();
        we1 = 1; waddr1 = 5; wdata1 = 32'hDEADBEEF;
        tick();
        idle_inputs(); addr1 = 5; #1;
        checks++;
        if (out1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_r5: got %h expected deadbeef", out1);
        end
        we1 = 1; waddr1 = 0; wdata1 = 32'h1234;
        we2 = 1; waddr2 = 0; wdata2 = 32'h5678;
        addr1 = 0; addr2 = 5; #1;
        checks++;
        if (out1 !== 32'h0) begin
            errors++;
            $display("FAIL write_r0_same_cycle: got %h expected 0", out1);
        end
        tick();
        idle_inputs(); #1;
        checks++;
        if (out1 !== 32'h0 || out2 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_r0_next: out1=%h out2=%h expected 0 / deadbeef", out1, out2);
        end
    endtask

    task automatic test_conflict();
        we1 = 1; waddr1 = 7; wdata1 = 32'h1;
        we2 = 1; waddr2 = 7; wdata2 = 32'h2;
        tick();
        idle_inputs(); addr1 = 7; addr2 = 7; #1;
        checks++;
        if (out1 !== 32'h2 || out2 !== 32'h2) begin
            errors++;
            $display("FAIL conflict_r7: out1=%h out2=%h expected 2", out1, out2);
        end
    endtask

    task automatic test_busy();
        bset = 1; baddr = 9;
        tick();
        idle_inputs(); addr1 = 9; addr2 = 8; #1;
        checks++;
        if (busy1 !== 1'b1 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL busy_set_r9: busy1=%b busy2=%b expected 1/0", busy1, busy2);
        end
        we2 = 1; waddr2 = 9; wdata2 = 32'h900D;
        tick();
        idle_inputs(); #1;
        checks++;
        if (busy1 !== 1'b0 || out1 !== 32'h900D) begin
            errors++;
            $display("FAIL busy_clear_r9: busy1=%b out1=%h expected 0/900d", busy1, out1);
        end
        bset = 1; baddr = 9; we1 = 1; waddr1 = 9; wdata1 = 32'h99;
        tick();
        idle_inputs(); #1;
        checks++;
        if (busy1 !== 1'b1 || out1 !== 32'h99) begin
            errors++;
            $display("FAIL busy_set_wins_r9: busy1=%b out1=%h expected 1/99", busy1, out1);
        end
        bset = 1; baddr = 0;
        tick();
        idle_inputs(); addr2 = 0; #1;
        checks++;
        if (busy2 !== 1'b0) begin
            errors++;
            $display("FAIL busy_r0: busy2=%b expected 0", busy2);
        end
        we1 = 1; waddr1 = 9; wdata1 = 32'h99;
        tick();
        idle_inputs();
    endtask

    task automatic test_bypass();
        we1 = 1; waddr1 = 3; wdata1 = 32'h11;
        tick();
        idle_inputs(); bset = 1; baddr = 3;
        tick();
        idle_inputs();
        we1 = 1; waddr1 = 3; wdata1 = 32'hAA; addr1 = 3; addr2 = 2; #1;
        checks++;
`ifdef REG_BYPASS_EN
        if (out1 !== 32'hAA || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL bypass_same_cycle: out1=%h busy1=%b expected aa/0", out1, busy1);
        end
`else
        if (out1 !== 32'h11 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL no_bypass_same_cycle: out1=%h busy1=%b expected 11/1", out1, busy1);
        end
`endif
        tick();
        idle_inputs(); #1;
        checks++;
        if (out1 !== 32'hAA || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL write_r3_next: out1=%h busy1=%b expected aa/0", out1, busy1);
        end
        we1 = 1; waddr1 = 3; wdata1 = 32'hB1;
        we2 = 1; waddr2 = 3; wdata2 = 32'hB2; addr2 = 3; #1;
        checks++;
`ifdef REG_BYPASS_EN
        if (out2 !== 32'hB2) begin
            errors++;
            $display("FAIL bypass_port2_priority: out2=%h expected b2", out2);
        end
`else
        if (out2 !== 32'hAA) begin
            errors++;
            $display("FAIL no_bypass_dual: out2=%h expected aa", out2);
        end
`endif
        tick();
        idle_inputs(); #1;
        checks++;
        if (out2 !== 32'hB2) begin
            errors++;
            $display("FAIL dual_write_r3_next: out2=%h expected b2", out2);
        end
    endtask

    task automatic test_reset_drop();
        we1 = 1; waddr1 = 4; wdata1 = 32'h55; bset = 1; baddr = 6;
        tick();
        idle_inputs();
        rst = 1; we1 = 1; waddr1 = 4; wdata1 = 32'h77; bset = 1; baddr = 4;
        addr1 = 4; addr2 = 6; #1;
        checks++;
`ifdef REG_BYPASS_EN
        if (out1 !== 32'h0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_cycle_bypass: out1=%h busy2=%b expected 0/0", out1, busy2);
        end
`else
        if (out1 !== 32'h55 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL reset_cycle_stored: out1=%h busy2=%b expected 55/1", out1, busy2);
        end
`endif
        tick();
        rst = 0; idle_inputs(); #1;
        checks++;
        if (out1 !== 32'h0 || out2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_drop_data: out1=%h out2=%h expected 0", out1, out2);
        end
        checks++;
        if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop_busy: busy1=%b busy2=%b expected 0", busy1, busy2);
        end
        addr1 = 7; addr2 = 3; #1;
        checks++;
        if (out1 !== 32'h0 || out2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_clears_others: out1=%h out2=%h expected 0", out1, out2);
        end
    endtask

    initial begin
        rst = 1; idle_inputs(); addr1 = '0; addr2 = '0;
        test_reset();
        test_write();
        test_conflict();
        test_busy();
        test_bypass();
        test_reset_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
